// File: rtl/matrix_c_reader.sv
// Streams the 2**AW-element result matrix out of a synchronous-read RAM via a 2-entry FIFO.
// Define MATRIX_C_READER_TRANSPOSE_EN to stream column-major instead of row-major.
module matrix_c_reader #(
   parameter int unsigned DW = 19,
   parameter int unsigned AW = 6
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   output logic [AW-1:0]        c_addr,
   output logic                 c_en,
   input  logic signed [DW-1:0] c_rdata,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [DW-1:0] out_data,
   output logic                 out_last,
   output logic                 busy,
   output logic                 done
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   localparam logic [AW-1:0] LastIdx = '1;
   localparam logic [AW:0]   RdOne   = 1;
   localparam logic [AW-1:0] TxOne   = 1;

   state_e               state_q, state_d;
   logic [AW:0]          rd_idx_q;     // MSB set once every element has been read
   logic [AW-1:0]        tx_idx_q;
   logic                 inflight_q;
   logic signed [DW-1:0] fifo_q [2];
   logic                 wr_ptr_q, rd_ptr_q;
   logic [1:0]           count_q;
   logic                 pop, launch, begin_pass;
   logic [2:0]           occupancy;
   logic [AW-1:0]        map_addr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) state_d = StRun;
         end
         StRun: begin
            busy = 1'b1;
            if (pop && out_last) state_d = StDone;
         end
         StDone: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign begin_pass = (state_q == StIdle) && start;
   assign out_valid  = (count_q != 2'd0);
   assign out_data   = fifo_q[rd_ptr_q];
   assign out_last   = out_valid && (tx_idx_q == LastIdx);
   assign pop        = out_valid && out_ready;

   // Reserve a FIFO slot for every read still in flight so the FIFO never overflows.
   assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign launch    = (state_q == StRun) && !rd_idx_q[AW] && (occupancy < 3'd2);
   assign c_en      = launch;

`ifdef MATRIX_C_READER_TRANSPOSE_EN
   assign map_addr = {rd_idx_q[AW/2-1:0], rd_idx_q[AW-1:AW/2]};
`else
   assign map_addr = rd_idx_q[AW-1:0];
`endif
   assign c_addr = c_en ? map_addr : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_idx_q   <= '0;
         tx_idx_q   <= '0;
         inflight_q <= 1'b0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= '0;
         fifo_q[0]  <= '0;
         fifo_q[1]  <= '0;
      end else begin
         inflight_q <= launch;
         if (begin_pass) begin
            rd_idx_q <= '0;
            tx_idx_q <= '0;
         end else begin
            if (launch) rd_idx_q <= rd_idx_q + RdOne;
            if (pop)    tx_idx_q <= tx_idx_q + TxOne;
         end
         if (inflight_q) begin
            fifo_q[wr_ptr_q] <= c_rdata;
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + {1'b0, inflight_q} - {1'b0, pop};
      end
   end

endmodule

// File: tb/tb_matrix_c_reader.sv
// Directed bench for matrix_c_reader: RAM preloaded with C[i] = 3*i - 100, stream checked beat by beat.
`timescale 1ns/1ps
module tb_matrix_c_reader;

   localparam int DW = 19;
   localparam int AW = 6;
   localparam int N  = 64;

   logic                 clk = 1'b0;
   logic                 reset, start, out_ready;
   logic                 c_en, out_valid, out_last, busy, done;
   logic [AW-1:0]        c_addr;
   logic signed [DW-1:0] c_rdata, out_data;
   logic signed [DW-1:0] ram [N];

   int checks = 0;
   int errors = 0;

   logic signed [DW-1:0] beats [$];
   logic                 lasts [$];
   int                   addrs [$];
   int cyc, first_en_cyc, first_valid_cyc, last_hs_cyc, done_cyc, done_cnt;

   matrix_c_reader #(.DW(DW), .AW(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .c_addr    (c_addr),
      .c_en      (c_en),
      .c_rdata   (c_rdata),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (c_en) c_rdata <= ram[c_addr];
   end

   function automatic int exp_addr(input int i);
`ifdef MATRIX_C_READER_TRANSPOSE_EN
      return (i % 8) * 8 + i / 8;
`else
      return i;
`endif
   endfunction

   function automatic logic signed [DW-1:0] exp_data(input int i);
      return DW'(3 * exp_addr(i) - 100);
   endfunction

   task automatic clear_logs();
      beats.delete();
      lasts.delete();
      addrs.delete();
      cyc             = 0;
      first_en_cyc    = -1;
      first_valid_cyc = -1;
      last_hs_cyc     = -1;
      done_cyc        = -1;
      done_cnt        = 0;
   endtask

   // Drive one cycle's inputs at the falling edge, then log what the DUT shows for that cycle.
   task automatic cycle(input logic rdy, input logic st);
      @(negedge clk);
      out_ready = rdy;
      start     = st;
      #1;
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
         beats.push_back(out_data);
         lasts.push_back(out_last);
         if (out_last) last_hs_cyc = cyc;
      end
      if (c_en) begin
         addrs.push_back(int'(c_addr));
         if (first_en_cyc < 0) first_en_cyc = cyc;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      cyc++;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if ({c_en, out_valid, out_last, busy, done} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl got %b want 00000", {c_en, out_valid, out_last, busy, done});
      end
      checks++;
      if (out_data !== '0) begin
         errors++;
         $display("FAIL reset_data got %0d want 0", out_data);
      end
      checks++;
      if (c_addr !== '0) begin
         errors++;
         $display("FAIL reset_addr got %0d want 0", c_addr);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_stream();
      clear_logs();
      cycle(1'b1, 1'b1);
      cycle(1'b1, 1'b0);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL stream_busy_run got %b want 1", busy);
      end
      while (done_cyc < 0 && cyc < 200) begin
         cycle(1'b1, 1'b0);
         if (done) begin
            checks++;
            if (busy !== 1'b1) begin
               errors++;
               $display("FAIL stream_busy_done got %b want 1", busy);
            end
         end
      end
      repeat (3) cycle(1'b1, 1'b0);
      checks++;
      if (first_en_cyc != 1) begin
         errors++;
         $display("FAIL stream_first_read cycle got %0d want 1", first_en_cyc);
      end
      checks++;
      if (first_valid_cyc != 3) begin
         errors++;
         $display("FAIL stream_first_valid cycle got %0d want 3", first_valid_cyc);
      end
      checks++;
      if (done_cyc < 0 || done_cyc != last_hs_cyc + 1) begin
         errors++;
         $display("FAIL stream_done_timing got %0d want %0d", done_cyc, last_hs_cyc + 1);
      end
      checks++;
      if (done_cnt != 1) begin
         errors++;
         $display("FAIL stream_done_count got %0d want 1", done_cnt);
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL stream_idle_after got busy=%b done=%b want 0 0", busy, done);
      end
      checks++;
      if (beats.size() != N || addrs.size() != N) begin
         errors++;
         $display("FAIL stream_count got beats=%0d reads=%0d want %0d", beats.size(), addrs.size(), N);
      end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (i >= beats.size() || i >= addrs.size()) begin
            errors++;
            $display("FAIL stream_beat %0d got none want %0d", i, exp_data(i));
         end else if (beats[i] !== exp_data(i) || lasts[i] !== (i == N - 1) ||
                      addrs[i] != exp_addr(i)) begin
            errors++;
            $display("FAIL stream_beat %0d got data=%0d last=%b addr=%0d want %0d %b %0d",
                     i, beats[i], lasts[i], addrs[i], exp_data(i), (i == N - 1), exp_addr(i));
         end
      end
   endtask

   task automatic test_toggle();
      logic p_valid, p_ready, p_last;
      logic signed [DW-1:0] p_data;
      clear_logs();
      cycle(1'b0, 1'b1);
      p_valid = out_valid; p_ready = out_ready; p_data = out_data; p_last = out_last;
      while (done_cyc < 0 && cyc < 400) begin
         cycle(cyc[0], 1'b0);
         if (p_valid && !p_ready) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== p_data || out_last !== p_last) begin
               errors++;
               $display("FAIL toggle_stall got v=%b d=%0d l=%b want 1 %0d %b",
                        out_valid, out_data, out_last, p_data, p_last);
            end
         end
         p_valid = out_valid; p_ready = out_ready; p_data = out_data; p_last = out_last;
      end
      repeat (2) cycle(1'b1, 1'b0);
      checks++;
      if (beats.size() != N || done_cnt != 1) begin
         errors++;
         $display("FAIL toggle_count got beats=%0d dones=%0d want %0d 1", beats.size(), done_cnt, N);
      end
      for (int i = 0; i < N && i < beats.size(); i++) begin
         checks++;
         if (beats[i] !== exp_data(i) || lasts[i] !== (i == N - 1)) begin
            errors++;
            $display("FAIL toggle_beat %0d got %0d last=%b want %0d", i, beats[i], lasts[i], exp_data(i));
         end
      end
   endtask

   task automatic test_stall();
      clear_logs();
      cycle(1'b0, 1'b1);
      while (!out_valid && cyc < 10) cycle(1'b0, 1'b0);
      for (int k = 0; k < 10; k++) begin
         cycle(1'b0, 1'b0);
         checks++;
         if (out_valid !== 1'b1 || out_data !== exp_data(0)) begin
            errors++;
            $display("FAIL stall_hold got v=%b d=%0d want 1 %0d", out_valid, out_data, exp_data(0));
         end
      end
      checks++;
      if (addrs.size() > 2) begin
         errors++;
         $display("FAIL stall_reads got %0d want at most 2", addrs.size());
      end
      while (done_cyc < 0 && cyc < 300) cycle(1'b1, 1'b0);
      checks++;
      if (beats.size() != N) begin
         errors++;
         $display("FAIL stall_count got %0d want %0d", beats.size(), N);
      end
      for (int i = 0; i < N && i < beats.size(); i++) begin
         checks++;
         if (beats[i] !== exp_data(i)) begin
            errors++;
            $display("FAIL stall_beat %0d got %0d want %0d", i, beats[i], exp_data(i));
         end
      end
   endtask

   task automatic test_reset_mid();
      clear_logs();
      cycle(1'b1, 1'b1);
      while (beats.size() < 21 && cyc < 100) cycle(1'b1, 1'b0);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({c_en, out_valid, out_last, busy, done} !== 5'b0) begin
         errors++;
         $display("FAIL midreset_ctrl got %b want 00000", {c_en, out_valid, out_last, busy, done});
      end
      checks++;
      if (out_data !== '0 || c_addr !== '0) begin
         errors++;
         $display("FAIL midreset_data got d=%0d a=%0d want 0 0", out_data, c_addr);
      end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      clear_logs();
      cycle(1'b1, 1'b1);
      while (done_cyc < 0 && cyc < 200) cycle(1'b1, 1'b0);
      checks++;
      if (beats.size() != N) begin
         errors++;
         $display("FAIL midreset_count got %0d want %0d", beats.size(), N);
      end
      for (int i = 0; i < N && i < beats.size(); i++) begin
         checks++;
         if (beats[i] !== exp_data(i)) begin
            errors++;
            $display("FAIL midreset_beat %0d got %0d want %0d", i, beats[i], exp_data(i));
         end
      end
   endtask

   task automatic test_start_during_run();
      clear_logs();
      cycle(1'b1, 1'b1);
      while (done_cyc < 0 && cyc < 200) cycle(1'b1, (cyc == 15 || cyc == 40));
      repeat (3) cycle(1'b1, 1'b0);
      checks++;
      if (done_cnt != 1 || beats.size() != N) begin
         errors++;
         $display("FAIL rerun_count got dones=%0d beats=%0d want 1 %0d", done_cnt, beats.size(), N);
      end
      for (int i = 0; i < N && i < beats.size(); i++) begin
         checks++;
         if (beats[i] !== exp_data(i) || lasts[i] !== (i == N - 1)) begin
            errors++;
            $display("FAIL rerun_beat %0d got %0d last=%b want %0d", i, beats[i], lasts[i], exp_data(i));
         end
      end
   endtask

   initial begin
      c_rdata = '0;
      for (int i = 0; i < N; i++) ram[i] = DW'(3 * i - 100);
      test_reset();
      test_stream();
      test_toggle();
      test_stall();
      test_reset_mid();
      test_start_during_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/matrix_c_reader.md
MATRIX_C_READER -- requirements
Module: matrix_c_reader

Interface
REQ-001 SHALL have parameter DW, default 19, meaning the result element width in bits (signed).
REQ-002 SHALL have parameter AW, default 6, meaning the result RAM address width; the matrix holds 2**AW elements; AW SHALL be even.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, a request to begin one readout pass of the result matrix.
REQ-006 SHALL have port c_addr, output, AW, the result RAM read address.
REQ-007 SHALL have port c_en, output, 1, the read strobe; high for exactly the cycles in which a read is issued.
REQ-008 SHALL have port c_rdata, input signed, DW, the result RAM read data, valid the cycle after the cycle c_en was high.
REQ-009 SHALL have port out_valid, output, 1, meaning out_data holds an element.
REQ-010 SHALL have port out_ready, input, 1, meaning the sink accepts the element.
REQ-011 SHALL have port out_data, output signed, DW, the element being offered.
REQ-012 SHALL have port out_last, output, 1, marking the final element (index 2**AW-1) of the pass.
REQ-013 SHALL have port busy, output, 1, high while a pass is in progress.
REQ-014 SHALL have port done, output, 1, a one-cycle pulse at the end of a pass.

Function
REQ-015 SHALL have states IDLE, RUN, DONE; IDLE to RUN when start is sampled high, RUN to DONE on the last-element handshake, DONE to IDLE after one cycle.
REQ-016 SHALL ignore start outside IDLE.
REQ-017 SHALL hold busy=1 in RUN and DONE only; SHALL hold done=1 in DONE only.
REQ-018 SHALL define the read index rd_idx as 0..2**AW-1, incrementing by one per issued read, with no reads issued once rd_idx has passed the last element.
REQ-019 SHALL drive c_addr = rd_idx (row-major) during a read.
REQ-020 SHALL capture c_rdata into a 2-entry output FIFO on the cycle after each read.
REQ-021 SHALL issue a read only when (FIFO count + reads in flight - pop this cycle) < 2, so the FIFO never overflows.
REQ-022 SHALL drive out_valid = FIFO not empty and out_data = FIFO head.
REQ-023 SHALL hold out_data and out_last stable while out_valid=1 and out_ready=0.
REQ-024 SHALL transfer an element when out_valid and out_ready are both high.
REQ-025 SHALL assert out_last with the element at transmit index 2**AW-1 only.
REQ-026 SHALL issue the first read in the cycle after start is sampled, and SHALL raise out_valid two edges after the start edge.
REQ-027 SHALL sustain one element per cycle while out_ready stays high.
REQ-028 SHALL raise done in the cycle after the last handshake; with out_ready held high, the last handshake falls 65 edges after start and done follows for one cycle (AW=6).
REQ-029 SHALL pass elements unmodified: no sign change and no truncation.

Reset
REQ-030 SHALL, on reset, immediately force state=IDLE, FIFO empty, indices 0, and c_en, out_valid, out_last, busy, done to 0; out_data and c_addr SHALL be 0.
REQ-031 SHALL discard an in-flight read on reset mid-pass; the next start SHALL restart at element 0.

Configuration
REQ-032 SHALL support macro MATRIX_C_READER_TRANSPOSE_EN: when defined, c_addr = {rd_idx[AW/2-1:0], rd_idx[AW-1:AW/2]}, so the matrix streams column-major; when undefined, the order is row-major per REQ-019.
REQ-033 SHALL leave handshake, timing and out_last placement identical in both builds.

Verification
REQ-034 SHALL cover: RAM preloaded with C[i]=3*i-100, start pulse, out_ready=1 -> 64 beats -100,-97,...,89 in order, out_last on beat 63 only, one done pulse, busy low afterwards.
REQ-035 SHALL cover: out_ready toggling every cycle -> 64 beats with no loss or duplication, and out_data stable across each stall.
REQ-036 SHALL cover: out_ready low for 10 cycles after the first valid -> out_valid held, data=-100, at most 2 reads issued, and the stream resumes in order.
REQ-037 SHALL cover: TRANSPOSE_EN build -> c_addr sequence 0,8,16,...,56,1,9,..., with data matching those addresses.
REQ-038 SHALL cover: reset asserted after beat 20 -> all outputs 0 asynchronously; the next start streams from element 0.
REQ-039 SHALL cover: start pulsed during RUN -> no effect on the sequence and exactly one done pulse.
